// File: rtl/clock_pkg.sv
// Shared constants for the HH:MM:SS timekeeping core: mode encodings,
// BCD field limits and digit width.
package clock_pkg;

  // BCD digit width used by every time field.
  localparam int DIGIT_W = 4;

  // Mode FSM encodings, also driven out unchanged on the mode port.
  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;

  // Terminal values of each two-digit field, written as packed BCD.
  localparam logic [2*DIGIT_W-1:0] SEC_MAX  = 8'h59;
  localparam logic [2*DIGIT_W-1:0] MIN_MAX  = 8'h59;
  localparam logic [2*DIGIT_W-1:0] HOUR_MAX = 8'h23;

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00. carry is
// combinational and marks the increment that performs the wrap, so a chain
// of these counters advances in a single clock edge.
module bcd2_mod_counter
  import clock_pkg::*;
#(
  parameter logic [2*DIGIT_W-1:0] MAX = SEC_MAX
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units,
  output logic               carry
);

  logic at_max;

  assign at_max = ({tens, units} == MAX);
  assign carry  = inc & at_max;

  // Count in BCD: units wrap 9->0 into tens, whole field wraps MAX->00.
  // clr beats inc so a field clear never leaves a half-incremented value.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tens  <= '0;
      units <= '0;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= '0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_counter_hms.sv
// Timekeeping core: edge-detects the divider tick, prescales it to seconds
// and keeps HH:MM:SS in BCD (24-hour). A RUN / SET_HOUR / SET_MIN mode FSM
// lets the two buttons set hours and minutes.
//
// Input semantics: tick_in is a level whose rising edges are counted;
// btn_mode and btn_inc are single-cycle pulses acted on at the edge where
// they are high. There is no backpressure; nothing is ever stalled or held.
module time_counter_hms
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int PRE_W         = $clog2(TICKS_PER_SEC) + 1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic [1:0]  mode
);

  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICKS_PER_SEC - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               tick_q;
  logic               tick_rise;
  logic [PRE_W-1:0]   prescaler;
  logic               in_run;
  logic               step;
  logic               leave_set_min;
  logic               hour_set_inc;
  logic               min_set_inc;
  logic               sec_carry;
  logic               min_carry;
  logic               hour_carry;
  logic [DIGIT_W-1:0] s_tens, s_units;
  logic [DIGIT_W-1:0] m_tens, m_units;
  logic [DIGIT_W-1:0] h_tens, h_units;

  assign in_run    = (state == MODE_RUN);
  assign tick_rise = tick_in & ~tick_q;

  // A second step lands on the same edge that sees the terminal tick.
  assign step = in_run & tick_rise & (prescaler == PRE_TERM);

  // Leaving SET_MIN restarts RUN at a clean second boundary.
  assign leave_set_min = (state == MODE_SET_MIN) & btn_mode;

  // A mode press in the same cycle swallows the increment press.
  assign hour_set_inc = (state == MODE_SET_HOUR) & btn_inc & ~btn_mode;
  assign min_set_inc  = (state == MODE_SET_MIN)  & btn_inc & ~btn_mode;

  // Next mode on a btn_mode press; an unused encoding falls back to RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      MODE_RUN:      if (btn_mode) state_nxt = MODE_SET_HOUR;
      MODE_SET_HOUR: if (btn_mode) state_nxt = MODE_SET_MIN;
      MODE_SET_MIN:  if (btn_mode) state_nxt = MODE_RUN;
      default:       state_nxt = MODE_RUN;
    endcase
  end

  // Mode register; also the externally visible mode.
  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= MODE_RUN;
    else        state <= state_nxt;
  end

  // Previous tick level for rising-edge detection.
  always_ff @(posedge clk_in) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_in;
  end

  // Prescaler counts tick edges in RUN and holds while a field is being set.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (leave_set_min) begin
      prescaler <= '0;
    end else if (in_run && tick_rise) begin
      if (prescaler == PRE_TERM) prescaler <= '0;
      else                       prescaler <= prescaler + 1'b1;
    end
  end

  // One-cycle marker aligned with the edge that advanced the seconds.
  always_ff @(posedge clk_in) begin
    if (!rst_n) sec_pulse <= 1'b0;
    else        sec_pulse <= step;
  end

  bcd2_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (step),
    .clr    (leave_set_min),
    .tens   (s_tens),
    .units  (s_units),
    .carry  (sec_carry)
  );

  bcd2_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (sec_carry | min_set_inc),
    .clr    (1'b0),
    .tens   (m_tens),
    .units  (m_units),
    .carry  (min_carry)
  );

  // Minute wrap only reaches the hours while running; setting minutes
  // wraps them in place.
  bcd2_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    ((min_carry & in_run) | hour_set_inc),
    .clr    (1'b0),
    .tens   (h_tens),
    .units  (h_units),
    .carry  (hour_carry)
  );

  // Hours wrap 23->00 with nowhere further to carry.
  logic unused_hour_carry;
  assign unused_hour_carry = hour_carry;

  assign time_bcd = {h_tens, h_units, m_tens, m_units, s_tens, s_units};
  assign mode     = state;

endmodule
